// File: rtl/sipo_deserializer.sv
// sipo_deserializer: LSB-first serial-to-parallel receiver with a one-word holding register.
// Define PARITY_CHECK_EN to append an even-parity bit to every frame and report errors.
module sipo_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_i,
  input  logic             valid_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] parallel_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             parity_err_o
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef PARITY_CHECK_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             completing;
  logic             hold_free;

`ifdef PARITY_CHECK_EN
  localparam logic [CW-1:0] DATA_BITS = CW'(WIDTH);
  logic perr_q, perr_d;

  // Returns 1 when data plus parity bit do not form even parity.
  function automatic logic parity_bad(input logic [WIDTH-1:0] data, input logic pbit);
    return (^data) ^ pbit;
  endfunction
`endif

  // Next-state logic: bit collection, completion hand-off and holding-register drain.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    par_d      = par_q;
    valid_d    = valid_q & ~ready_i;
    ovr_d      = 1'b0;
    shifted    = {serial_i, sr_q[WIDTH-1:1]};
    hold_free  = ~valid_q | ready_i;
    completing = valid_i & ~clr_i & (cnt_q == LAST_BIT);
`ifdef PARITY_CHECK_EN
    perr_d = 1'b0;
    word   = sr_q;
`else
    word   = shifted;
`endif

    if (clr_i) begin
      state_d = IDLE;
      cnt_d   = CNT_ZERO;
    end else if (valid_i) begin
`ifdef PARITY_CHECK_EN
      // The trailing parity bit is checked but never shifted into the data word.
      if (cnt_q < DATA_BITS) begin
        sr_d = shifted;
      end else begin
        sr_d = sr_q;
      end
`else
      sr_d = shifted;
`endif
      case (state_q)
        IDLE: begin
          state_d = SHIFT;
          cnt_d   = cnt_q + CNT_ONE;
        end
        SHIFT: begin
          if (completing) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = SHIFT;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
      if (completing) begin
        if (hold_free) begin
          par_d   = word;
          valid_d = 1'b1;
        end else begin
          ovr_d   = 1'b1;
        end
`ifdef PARITY_CHECK_EN
        perr_d = parity_bad(sr_q, serial_i);
`endif
      end else begin
        ovr_d = 1'b0;
      end
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      sr_q    <= {WIDTH{1'b0}};
      par_q   <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef PARITY_CHECK_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign parallel_o = par_q;
  assign valid_o    = valid_q;
  assign busy_o     = (cnt_q != CNT_ZERO);
  assign overrun_o  = ovr_q;
`ifdef PARITY_CHECK_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule
